dm_responder: RTL



---
 rtl/dm_responder_pkg.sv | 19 +
 rtl/dm_array.sv | 21 ++
 rtl/dm_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dm_responder_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dm_responder_pkg;

  localparam int unsigned REQ_ADDR_W = 16;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/dm_array.sv
// Data-memory storage: synchronous write, combinational read (registered by the parent).
module dm_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with stall handshake toward the core.
// Optional DM_ADDR_CHK_EN: out-of-range addresses raise err, suppress writes, read all-ones.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic                  req_re,
  input  logic                  req_we,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  hlt,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  err
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oob_q;

  logic                accept;
  logic                fin;
  op_t                 acc_op;
  logic [CNT_W-1:0]    acc_lat;
  logic                acc_oob;
  op_t                 fin_op;
  logic [ADDR_W-1:0]   fin_addr;
  logic [DATA_W-1:0]   fin_wdata;
  logic                fin_oob;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_rdata;

`ifdef DM_ADDR_CHK_EN
  assign acc_oob = |req_addr[REQ_ADDR_W-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[REQ_ADDR_W-1:ADDR_W];
  assign acc_oob = 1'b0;
`endif

  // Next state, accept/finish strobes and the operation committed on entry to DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    fin       = 1'b0;
    stall     = 1'b0;
    acc_op    = req_we ? OP_WR : OP_RD;
    acc_lat   = req_we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
    fin_op    = op_q;
    fin_addr  = addr_q;
    fin_wdata = wdata_q;
    fin_oob   = oob_q;
    case (state_q)
      ST_IDLE: begin
        if ((req_re || req_we) && !hlt) begin
          accept    = 1'b1;
          stall     = 1'b1;
          fin_op    = acc_op;
          fin_addr  = req_addr[ADDR_W-1:0];
          fin_wdata = req_wdata;
          fin_oob   = acc_oob;
          if (acc_lat == CNT_W'(1)) begin
            state_d = ST_DONE;
            fin     = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = acc_lat - CNT_W'(2);
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          fin     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Reset forces the idle view immediately, before the next clock.
    if (rst) begin
      stall  = 1'b0;
      accept = 1'b0;
      fin    = 1'b0;
    end
  end

  assign arr_we = fin && (fin_op == OP_WR) && !fin_oob && !rst;

  dm_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (fin_addr),
    .wdata (fin_wdata),
    .rdata (arr_rdata)
  );

  // State, counter, latched request and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      oob_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        op_q    <= acc_op;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        oob_q   <= acc_oob;
      end
      rsp_valid <= fin;
      err       <= fin && fin_oob;
      if (fin && (fin_op == OP_RD)) rsp_rdata <= fin_oob ? '1 : arr_rdata;
    end
  end

endmodule
